instrumented_adder_sequencer: RTL and testbench

Parametrised measurement sequencer for the instrumented-adder macros. It selects one of NUM_CH ring-oscillator adder channels and drives the operands. It checks the adder sum against an internal reference, then counts ring toggles over a programmable gate window. Modes are single-shot and repeat. Sits between the logic-analyser register bank and the adder-under-test macros inside the project wrapper.

---
 rtl/instr_adder_pkg.sv | 15 +
 rtl/ring_edge_sync.sv | 24 ++
 rtl/instrumented_adder_sequencer.sv | 166 ++++++++++++++++
 tb/tb_instrumented_adder_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_adder_pkg.sv
// Shared types and constants for the instrumented-adder sequencer.
package instr_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        MEASURE,
        REPORT
    } state_t;

    localparam int         DEF_WIDTH   = 32;
    localparam int         DEF_COUNT_W = 24;
    localparam logic [7:0] RUNS_MAX    = 8'hFF;

endpackage

// File: rtl/ring_edge_sync.sv
// Two-flop synchroniser for one ring tap plus a registered rising-edge pulse.
module ring_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ring_i,
    output logic rise_o
);

    logic [2:0] sync_q;
    logic       rise_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], ring_i};
            rise_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/instrumented_adder_sequencer.sv
// Drives operands into one adder channel, checks its sum, then counts
// ring-oscillator edges over a gated window in single-shot or repeat mode.
module instrumented_adder_sequencer
    import instr_adder_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_CH  = 4,
    parameter int COUNT_W = DEF_COUNT_W,
    parameter int SETTLE  = 4,
    parameter int GATE_W  = COUNT_W
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      mode,
    input  logic [$clog2(NUM_CH)-1:0] ch_sel,
    input  logic [WIDTH-1:0]          a_in,
    input  logic [WIDTH-1:0]          b_in,
    input  logic [GATE_W-1:0]         gate_cycles,
    input  logic [NUM_CH-1:0]         ring_in,
    input  logic [WIDTH:0]            dut_sum,
    output logic [WIDTH-1:0]          dut_a,
    output logic [WIDTH-1:0]          dut_b,
    output logic [NUM_CH-1:0]         dut_en,
    output logic                      busy,
    output logic                      done,
    output logic [COUNT_W-1:0]        count,
    output logic                      sum_ok,
    output logic                      overflow,
    output logic [7:0]                runs
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int SET_W = $clog2(SETTLE + 1);
    localparam int CNT_W = (GATE_W > SET_W) ? GATE_W : SET_W;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GATE_W-1:0]  gate_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [CH_W-1:0]    ch_q;
    logic               mode_q, stop_q;
    logic [NUM_CH-1:0]  en_q, rise;
    logic [COUNT_W-1:0] acc_q, acc_d, count_q;
    logic               acc_ovf_q, acc_ovf_d;
    logic               ovf_q, sum_ok_q, done_q;
    logic [7:0]         runs_q;
    logic               last_cnt, again;

    // Tap selection happens after synchronisation so switching is glitch-free
    for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
        ring_edge_sync u_sync (
            .clk_i  (wb_clk_i),
            .rst_ni (wb_rst_n),
            .ring_i (ring_in[i]),
            .rise_o (rise[i])
        );
    end

    assign last_cnt = (cnt_q == CNT_W'(1));
    assign again    = mode_q & ~stop_q & ~stop;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)    state_d = SETUP;
            SETUP:   if (last_cnt) state_d = MEASURE;
            MEASURE: if (last_cnt) state_d = REPORT;
            REPORT:  state_d = again ? MEASURE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        done     = done_q;
        count    = count_q;
        sum_ok   = sum_ok_q;
        overflow = ovf_q;
        runs     = runs_q;
        dut_a    = a_q;
        dut_b    = b_q;
        dut_en   = en_q;
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case (state_q)
            IDLE:    if (start) cnt_d = CNT_W'(SETTLE);
            SETUP:   cnt_d = last_cnt ? CNT_W'(gate_q) : cnt_q - CNT_W'(1);
            MEASURE: cnt_d = cnt_q - CNT_W'(1);
            REPORT:  cnt_d = CNT_W'(gate_q);
            default: cnt_d = cnt_q;
        endcase
    end

    // Accumulator only lives in MEASURE; it reads as zero everywhere else
    always_comb begin
        acc_d     = '0;
        acc_ovf_d = 1'b0;
        if (state_q == MEASURE) begin
            acc_d     = acc_q;
            acc_ovf_d = acc_ovf_q;
            if (rise[ch_q]) begin
                if (&acc_q) acc_ovf_d = 1'b1;
                else        acc_d     = acc_q + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            cnt_q     <= '0;
            gate_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            ch_q      <= '0;
            mode_q    <= 1'b0;
            stop_q    <= 1'b0;
            en_q      <= '0;
            acc_q     <= '0;
            acc_ovf_q <= 1'b0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            sum_ok_q  <= 1'b0;
            done_q    <= 1'b0;
            runs_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            acc_ovf_q <= acc_ovf_d;
            done_q    <= 1'b0;
            if (state_q != IDLE && stop) stop_q <= 1'b1;
            if (state_q == IDLE && start) begin
                a_q      <= a_in;
                b_q      <= b_in;
                ch_q     <= ch_sel;
                mode_q   <= mode;
                gate_q   <= (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
                en_q     <= NUM_CH'(1) << ch_sel;
                stop_q   <= 1'b0;
                runs_q   <= '0;
                count_q  <= '0;
                ovf_q    <= 1'b0;
                sum_ok_q <= 1'b0;
            end
            if (state_q == SETUP && last_cnt)
                sum_ok_q <= (dut_sum == ({1'b0, a_q} + {1'b0, b_q}));
            // Results land with done so they are valid during REPORT
            if (state_q == MEASURE && last_cnt) begin
                done_q  <= 1'b1;
                count_q <= acc_d;
                ovf_q   <= acc_ovf_d;
                if (runs_q != RUNS_MAX) runs_q <= runs_q + 8'd1;
            end
            if (state_q == REPORT && !again) en_q <= '0;
        end
    end

endmodule

// File: tb/tb_instrumented_adder_sequencer.sv
// Scoreboard bench: stimulus queues expected window results, a monitor
// compares them against each done pulse.
module tb_instrumented_adder_sequencer;

    localparam int WIDTH   = 32;
    localparam int NUM_CH  = 4;
    localparam int COUNT_W = 4;
    localparam int GATE_W  = 8;
    localparam int SETTLE  = 4;

    typedef struct {
        int                cyc;
        int                lo;
        int                hi;
        bit                sok;
        bit                ovf;
        int                runs;
        logic [WIDTH-1:0]  a;
        logic [NUM_CH-1:0] en;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               mode = 1'b0;
    logic [1:0]         ch_sel = '0;
    logic [WIDTH-1:0]   a_in = '0;
    logic [WIDTH-1:0]   b_in = '0;
    logic [GATE_W-1:0]  gate_cycles = '0;
    logic [NUM_CH-1:0]  ring_in = '0;
    logic [WIDTH:0]     dut_sum;
    logic [WIDTH-1:0]   dut_a, dut_b;
    logic [NUM_CH-1:0]  dut_en;
    logic               busy, done, sum_ok, overflow;
    logic [COUNT_W-1:0] count;
    logic [7:0]         runs;
    logic               sum_err = 1'b0;

    int   cyc = 0;
    int   tick = 0;
    int   half [NUM_CH] = '{0, 0, 0, 0};
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb [$];
    exp_t mon_e;

    instrumented_adder_sequencer #(
        .WIDTH   (WIDTH),
        .NUM_CH  (NUM_CH),
        .COUNT_W (COUNT_W),
        .SETTLE  (SETTLE),
        .GATE_W  (GATE_W)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_n    (rst_n),
        .start       (start),
        .stop        (stop),
        .mode        (mode),
        .ch_sel      (ch_sel),
        .a_in        (a_in),
        .b_in        (b_in),
        .gate_cycles (gate_cycles),
        .ring_in     (ring_in),
        .dut_sum     (dut_sum),
        .dut_a       (dut_a),
        .dut_b       (dut_b),
        .dut_en      (dut_en),
        .busy        (busy),
        .done        (done),
        .count       (count),
        .sum_ok      (sum_ok),
        .overflow    (overflow),
        .runs        (runs)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Adder model: honest sum, optionally off by one
    assign dut_sum = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, sum_err};

    // Free-running rings: channel i toggles every half[i] clocks
    always @(negedge clk) begin
        tick++;
        for (int i = 0; i < NUM_CH; i++)
            ring_in[i] = (half[i] != 0) && (((tick / half[i]) % 2) == 1);
    end

    task automatic chk(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done at cycle %0d, want none", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", cyc, mon_e.cyc);
                vectors++;
                if (int'(count) < mon_e.lo || int'(count) > mon_e.hi) begin
                    miscompares++;
                    $display("FAIL count: got %0d, want %0d..%0d",
                             count, mon_e.lo, mon_e.hi);
                end
                chk("sum_ok", sum_ok, mon_e.sok);
                chk("overflow", overflow, mon_e.ovf);
                chk("runs", runs, mon_e.runs);
                chk("dut_a", dut_a, mon_e.a);
                chk("dut_en", dut_en, mon_e.en);
                chk("busy_report", busy, 1);
            end
        end
    end

    task automatic issue(input int ch, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input int gate,
                         input bit md, input int nwin, input int lo,
                         input int hi, input bit sok, input bit ovf,
                         output int c);
        exp_t e;
        int   g;
        g = (gate == 0) ? 1 : gate;
        ch_sel      = 2'(ch);
        a_in        = a;
        b_in        = b;
        gate_cycles = GATE_W'(gate);
        mode        = md;
        start       = 1'b1;
        c           = cyc;
        for (int k = 0; k < nwin; k++) begin
            e.cyc  = c + SETTLE + g + 1 + k * (g + 1);
            e.lo   = lo;
            e.hi   = hi;
            e.sok  = sok;
            e.ovf  = ovf;
            e.runs = k + 1;
            e.a    = a;
            e.en   = NUM_CH'(1) << ch;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= bound) begin
            miscompares++;
            $display("FAIL %s_timeout: got busy after %0d cycles, want idle", name, n);
            sb.delete();
        end
        chk({name, "_idle_busy"}, busy, 0);
        chk({name, "_idle_en"}, dut_en, 0);
    endtask

    task automatic check_zero(input string p);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_done"}, done, 0);
        chk({p, "_count"}, count, 0);
        chk({p, "_sum_ok"}, sum_ok, 0);
        chk({p, "_overflow"}, overflow, 0);
        chk({p, "_runs"}, runs, 0);
        chk({p, "_dut_en"}, dut_en, 0);
        chk({p, "_dut_a"}, dut_a, 0);
        chk({p, "_dut_b"}, dut_b, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single shot; operand/channel changes while busy are ignored
        half[1] = 2;
        issue(1, 7, 9, 10, 0, 1, 2, 3, 1, 0, c);
        a_in   = 100;
        ch_sel = 2'd3;
        @(negedge clk);
        chk("sum_drive", dut_sum, 16);
        wait_idle("single", 40);
        chk("single_runs_hold", runs, 1);

        // Wrong sum still reports a count
        sum_err = 1'b1;
        half[0] = 1;
        issue(0, 5, 6, 3, 0, 1, 1, 2, 0, 0, c);
        wait_idle("wrong", 40);
        sum_err = 1'b0;

        // Full carry-out and counter saturation
        half[2] = 1;
        issue(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64, 0, 1, 15, 15, 1, 1, c);
        @(negedge clk);
        chk("carry_sum", dut_sum, 33'h1_FFFF_FFFE);
        wait_idle("sat", 120);

        // Stop while idle has no effect on the following repeat run
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        half[2] = 2;
        issue(2, 3, 4, 5, 1, 3, 1, 2, 1, 0, c);
        while (cyc < c + SETTLE + 2 * 6 + 2) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle("repeat", 60);
        chk("repeat_runs", runs, 3);

        // Zero gate behaves as a one-cycle window
        half[1] = 1;
        issue(1, 1, 2, 0, 0, 1, 0, 1, 1, 0, c);
        wait_idle("gate0", 30);

        // Start while busy is ignored
        half[3] = 2;
        issue(3, 10, 20, 10, 0, 1, 2, 3, 1, 0, c);
        a_in   = 99;
        ch_sel = 2'd0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("busy_start", 40);
        repeat (20) @(negedge clk);
        chk("busy_start_no_restart", busy, 0);
        chk("busy_start_runs", runs, 1);

        // Asynchronous reset during MEASURE, then a fresh run
        half[1] = 2;
        issue(1, 11, 22, 20, 0, 1, 0, 15, 1, 0, c);
        while (cyc < c + SETTLE + 3) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_zero("midrun");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1, 11, 22, 10, 0, 1, 2, 3, 1, 0, c);
        wait_idle("after_reset", 40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
